// File: rtl/link_pkg.sv
// Shared types and constants for the req/ack byte link receive path.
// Holds the rx state enum, byte width, sequence pattern and default burst length.
package link_pkg;

  localparam int LINK_BYTE_W = 8;
  localparam logic [3:0] LINK_PATTERN_HI = 4'hA;
  localparam int LINK_BURST_LEN_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    ACK   = 2'd2
  } rx_state_t;

  // Byte k of a well-formed burst.
  function automatic logic [LINK_BYTE_W-1:0] link_seq_byte(input int k);
    logic [1:0] k_lo;
    k_lo = k[1:0];
    return {LINK_PATTERN_HI, 2'b00, k_lo};
  endfunction

endpackage

// File: rtl/link_slave_rx_if.sv
// 4-phase req/ack byte link: master drives req/data/done_in, slave returns ack.
interface link_slave_rx_if;
  import link_pkg::*;

  logic                   req;
  logic [LINK_BYTE_W-1:0] data;
  logic                   done_in;
  logic                   ack;

  modport master (output req, output data, output done_in, input ack);
  modport slave  (input req, input data, input done_in, output ack);
endinterface

// File: rtl/link_rx_outbuf.sv
// Output holding register with valid/ready; a load on the handshake edge wins,
// so the register stays valid with the new word. Data is frozen while valid and unaccepted.
module link_rx_outbuf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] word_data,
  output logic             word_valid,
  input  logic             word_ready
);

  always_ff @(posedge clk) begin
    if (rst) begin
      word_data  <= '0;
      word_valid <= 1'b0;
    end else if (load) begin
      word_data  <= load_data;
      word_valid <= 1'b1;
    end else if (word_valid && word_ready) begin
      word_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/link_slave_rx.sv
// Link slave receiver: ack rises ACK_DELAY+1 cycles after req, BURST_LEN bytes form one word;
// the last byte of a burst stalls while the previous word is unaccepted. LINK_RX_SEQCHK_EN adds seq/frame checks.
module link_slave_rx
  import link_pkg::*;
#(
  parameter int BURST_LEN = LINK_BURST_LEN_DEF,
  parameter int ACK_DELAY = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  link_slave_rx_if.slave           lnk,
  output logic [8*BURST_LEN-1:0]   word_data,
  output logic                     word_valid,
  input  logic                     word_ready,
  output logic [7:0]               burst_count,
  output logic                     seq_err,
  output logic                     frame_err
);

  localparam int CW = $clog2(BURST_LEN);
  localparam int DW = $clog2(ACK_DELAY + 1);
  localparam int WW = LINK_BYTE_W * BURST_LEN;

  rx_state_t       state;
  logic            ack_q;
  logic [CW-1:0]   byte_cnt;
  logic [DW-1:0]   dly_cnt;
  logic [WW-1:0]   asm_q;
  logic [WW-1:0]   asm_next;
  logic            last_byte;
  logic            last_dly;
  logic            blocked;
  logic            capture;
  logic            load;

  assign last_byte = (byte_cnt == CW'(BURST_LEN - 1));
  assign last_dly  = (dly_cnt == DW'(ACK_DELAY - 1));
  assign blocked   = last_byte && word_valid && !word_ready;
  assign capture   = (state == DELAY) && lnk.req && last_dly;
  assign load      = capture && last_byte;
  assign lnk.ack   = ack_q;

  always_comb begin
    asm_next = asm_q;
    asm_next[byte_cnt*LINK_BYTE_W +: LINK_BYTE_W] = lnk.data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ack_q       <= 1'b0;
      byte_cnt    <= '0;
      dly_cnt     <= '0;
      asm_q       <= '0;
      burst_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (lnk.req && !blocked) begin
            state   <= DELAY;
            dly_cnt <= '0;
          end
        end
        DELAY: begin
          // A req drop before capture abandons the byte without touching byte_cnt.
          if (!lnk.req) begin
            state <= IDLE;
          end else if (last_dly) begin
            state    <= ACK;
            ack_q    <= 1'b1;
            asm_q    <= asm_next;
            byte_cnt <= last_byte ? '0 : byte_cnt + CW'(1);
            if (last_byte) burst_count <= burst_count + 8'd1;
          end else begin
            dly_cnt <= dly_cnt + DW'(1);
          end
        end
        ACK: begin
          if (!lnk.req) begin
            state <= IDLE;
            ack_q <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          ack_q <= 1'b0;
        end
      endcase
    end
  end

  link_rx_outbuf #(.WIDTH(WW)) u_outbuf (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_data  (asm_next),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_ready (word_ready)
  );

`ifdef LINK_RX_SEQCHK_EN
  logic seq_q;
  logic frame_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      seq_q   <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      if (capture && (lnk.data != link_seq_byte(int'(byte_cnt)))) seq_q <= 1'b1;
      // A byte in flight in DELAY counts as a partial burst even at byte_cnt 0.
      if (lnk.done_in && ((byte_cnt != '0) || (state == DELAY))) frame_q <= 1'b1;
    end
  end

  assign seq_err   = seq_q;
  assign frame_err = frame_q;
`else
  logic unused_done_in;
  assign unused_done_in = lnk.done_in;
  assign seq_err   = 1'b0;
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_link_slave_rx.sv
// Directed bench for link_slave_rx: burst, backpressure, abort, reset, checker and count wrap.
module tb_link_slave_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] word_data, word_data3;
  logic        word_valid, word_valid3;
  logic        word_ready = 1'b1;
  logic        word_ready3 = 1'b1;
  logic [7:0]  burst_count, burst_count3;
  logic        seq_err, frame_err, seq_err3, frame_err3;

  int n_tests = 0;
  int n_fail  = 0;

  logic        snap_vld;
  logic [31:0] snap_dat;
  logic [7:0]  snap_cnt;

`ifdef LINK_RX_SEQCHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  link_slave_rx_if lnk ();
  link_slave_rx_if lnk3 ();

  link_slave_rx #(.BURST_LEN(4), .ACK_DELAY(1)) u_dut (
    .clk(clk), .rst(rst), .lnk(lnk),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .burst_count(burst_count), .seq_err(seq_err), .frame_err(frame_err)
  );

  link_slave_rx #(.BURST_LEN(4), .ACK_DELAY(3)) u_dut3 (
    .clk(clk), .rst(rst), .lnk(lnk3),
    .word_data(word_data3), .word_valid(word_valid3), .word_ready(word_ready3),
    .burst_count(burst_count3), .seq_err(seq_err3), .frame_err(frame_err3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full 4-phase handshake on the ACK_DELAY=1 instance; lat = negedges from req to ack.
  task automatic send_byte(input logic [7:0] b, output int lat);
    int n;
    n = 0;
    lnk.req  = 1'b1;
    lnk.data = b;
    do begin @(negedge clk); n++; end while (!lnk.ack && n < 40);
    lat = n;
    snap_vld = word_valid;
    snap_dat = word_data;
    snap_cnt = burst_count;
    lnk.req = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (lnk.ack && n < 40);
    chk("ack_fall_lat", n, 1);
  endtask

  task automatic send_byte3(input logic [7:0] b, output int lat);
    int n;
    n = 0;
    lnk3.req  = 1'b1;
    lnk3.data = b;
    do begin @(negedge clk); n++; end while (!lnk3.ack && n < 40);
    lat = n;
    lnk3.req = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (lnk3.ack && n < 40);
    chk("ack3_fall_lat", n, 1);
  endtask

  task automatic send_burst(input logic [31:0] w);
    int lat;
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], lat);
  endtask

  initial begin
    int lat;
    int n;
    logic saw;
    logic [31:0] wb, wc;

    lnk.req = 1'b0;  lnk.data = 8'h00;  lnk.done_in = 1'b0;
    lnk3.req = 1'b0; lnk3.data = 8'h00; lnk3.done_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ack", lnk.ack, 0);
    chk("rst_valid", word_valid, 0);
    chk("rst_data", word_data, 0);
    chk("rst_count", burst_count, 0);
    chk("rst_seq_err", seq_err, 0);
    chk("rst_frame_err", frame_err, 0);
    rst = 1'b0;
    @(negedge clk);

    // Abort on the ACK_DELAY=3 instance: one-cycle req pulse.
    lnk3.req = 1'b1; lnk3.data = 8'hEE;
    @(negedge clk);
    lnk3.req = 1'b0;
    saw = 1'b0;
    repeat (8) begin @(negedge clk); if (lnk3.ack) saw = 1'b1; end
    chk("abort_no_ack", saw, 0);
    chk("abort_no_word", word_valid3, 0);
    send_byte3(8'hA0, lat);
    chk("delay3_ack_lat", lat, 4);
    send_byte3(8'hA1, lat);
    send_byte3(8'hA2, lat);
    word_ready3 = 1'b0;
    send_byte3(8'hA3, lat);
    chk("abort_word", word_data3, 32'hA3A2A1A0);
    chk("abort_count", burst_count3, 1);

    // Basic burst with a ready consumer.
    for (int k = 0; k < 4; k++) begin
      send_byte(8'hA0 + 8'(k), lat);
      chk($sformatf("basic_ack_lat%0d", k), lat, 2);
    end
    chk("basic_valid", snap_vld, 1);
    chk("basic_word", snap_dat, 32'hA3A2A1A0);
    chk("basic_count", snap_cnt, 1);
    chk("basic_valid_1cyc", word_valid, 0);

    // Backpressure: word B stays pending, C's last byte stalls until ready.
    word_ready = 1'b0;
    wb = 32'hB3B2B1B0;
    wc = 32'hC3C2C1C0;
    send_burst(wb);
    chk("bp_pending_valid", word_valid, 1);
    chk("bp_pending_word", word_data, wb);
    chk("bp_pending_count", burst_count, 2);
    for (int k = 0; k < 3; k++) begin
      send_byte(wc[8*k +: 8], lat);
      chk($sformatf("bp_ack_lat%0d", k), lat, 2);
    end
    lnk.req = 1'b1; lnk.data = wc[31:24];
    saw = 1'b0;
    repeat (6) begin @(negedge clk); if (lnk.ack) saw = 1'b1; end
    chk("bp_hold_ack", saw, 0);
    chk("bp_data_stable", word_data, wb);
    word_ready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!lnk.ack && n < 20);
    chk("bp_release_lat", n, 2);
    chk("bp_new_word", word_data, wc);
    chk("bp_new_valid", word_valid, 1);
    chk("bp_count", burst_count, 3);
    lnk.req = 1'b0;
    repeat (2) @(negedge clk);

    // Reset mid-burst while ack is high on byte 2.
    send_byte(8'hA0, lat);
    send_byte(8'hA1, lat);
    lnk.req = 1'b1; lnk.data = 8'hA2;
    n = 0;
    do begin @(negedge clk); n++; end while (!lnk.ack && n < 20);
    chk("rst_mid_ack_seen", lnk.ack, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_ack", lnk.ack, 0);
    chk("rst_mid_valid", word_valid, 0);
    chk("rst_mid_count", burst_count, 0);
    rst = 1'b0;
    lnk.req = 1'b0;
    repeat (2) @(negedge clk);
    send_burst(32'hD3D2D1D0);
    chk("rst_new_word", snap_dat, 32'hD3D2D1D0);
    chk("rst_new_count", snap_cnt, 1);

    // Burst counter wrap.
    for (int i = 0; i < 254; i++) send_burst(32'hA3A2A1A0);
    chk("wrap_255", burst_count, 255);
    send_burst(32'hA3A2A1A0);
    chk("wrap_0", burst_count, 0);

    // Sequence and framing checker.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_burst(32'hA3A2A1A0);
    chk("chk_clean_seq", seq_err, 0);
    send_burst(32'hA355A1A0);
    chk("chk_seq_err", seq_err, CHK_EN);
    chk("chk_seq_no_frame", frame_err, 0);
    send_byte(8'hA0, lat);
    send_byte(8'hA1, lat);
    lnk.done_in = 1'b1;
    @(negedge clk);
    lnk.done_in = 1'b0;
    send_byte(8'hA2, lat);
    send_byte(8'hA3, lat);
    chk("chk_frame_err", frame_err, CHK_EN);
    chk("chk_flow_word", snap_dat, 32'hA3A2A1A0);
    send_burst(32'hA3A2A1A0);
    chk("chk_seq_sticky", seq_err, CHK_EN);
    chk("chk_frame_sticky", frame_err, CHK_EN);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("chk_seq_clear", seq_err, 0);
    chk("chk_frame_clear", frame_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
